// File: rtl/sha1_round_ctrl.sv
// sha1_round_ctrl: SHA-1 block sequencer driving load, round and hash-accumulate enables.
module sha1_round_ctrl #(
  parameter int ROUNDS = 80,
  parameter int WORDS  = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start,
  input  logic        first_block,
  input  logic        abort,
  output logic        init_hash,
  output logic        w_load,
  output logic [3:0]  w_addr,
  output logic        round_en,
  output logic [6:0]  round_idx,
  output logic        w_sched,
  output logic [1:0]  f_sel,
  output logic [31:0] k_const,
  output logic        add_hash,
  output logic        busy,
  output logic        done,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE, LOAD, ROUND, FINAL} state_t;
  localparam logic [6:0] LAST_W = 7'(WORDS - 1);
  localparam logic [6:0] LAST_R = 7'(ROUNDS - 1);
  localparam logic [6:0] SCHED  = 7'(WORDS);
  localparam logic [6:0] Q1     = 7'(ROUNDS / 4);
  localparam logic [6:0] Q2     = 7'(ROUNDS / 2);
  localparam logic [6:0] Q3     = 7'(3 * (ROUNDS / 4));
  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [1:0]  f_sel_q, f_sel_d;
  logic        done_q, done_d, irq_q, irq_d, init_hash_q, init_hash_d;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    irq_d       = 1'b0;
    init_hash_d = 1'b0;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          state_d     = LOAD;
          done_d      = 1'b0;
          init_hash_d = first_block;
        end
        LOAD: begin
          state_d = (cnt_q == LAST_W) ? ROUND : LOAD;
          cnt_d   = (cnt_q == LAST_W) ? '0 : cnt_q + 7'd1;
        end
        ROUND: begin
          state_d = (cnt_q == LAST_R) ? FINAL : ROUND;
          cnt_d   = (cnt_q == LAST_R) ? '0 : cnt_q + 7'd1;
        end
        FINAL: begin
          state_d = IDLE;
          done_d  = 1'b1;
          irq_d   = 1'b1;
        end
      endcase
    end
    // quarter selection looks ahead so f_sel/k_const line up with round_idx
    f_sel_d = (state_d != ROUND) ? 2'd0 :
              (cnt_d < Q1) ? 2'd0 :
              (cnt_d < Q2) ? 2'd1 :
              (cnt_d < Q3) ? 2'd2 : 2'd3;
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      f_sel_q     <= '0;
      done_q      <= 1'b0;
      irq_q       <= 1'b0;
      init_hash_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      f_sel_q     <= f_sel_d;
      done_q      <= done_d;
      irq_q       <= irq_d;
      init_hash_q <= init_hash_d;
    end
  end
  assign w_load    = state_q == LOAD;
  assign w_addr    = w_load ? cnt_q[3:0] : 4'd0;
  assign round_en  = state_q == ROUND;
  assign round_idx = round_en ? cnt_q : 7'd0;
  assign w_sched   = round_en && (cnt_q >= SCHED);
  assign add_hash  = state_q == FINAL;
  assign busy      = state_q != IDLE;
  assign f_sel     = f_sel_q;
  assign k_const   = (f_sel_q == 2'd0) ? 32'h5A827999 :
                     (f_sel_q == 2'd1) ? 32'h6ED9EBA1 :
                     (f_sel_q == 2'd2) ? 32'h8F1BBCDC : 32'hCA62C1D6;
  assign done      = done_q;
  assign irq       = irq_q;
  assign init_hash = init_hash_q;
endmodule
